// File: rtl/seq6_pkg.sv
// Shared definitions for the 6-state sequence counter controller: op codes,
// FSM states and the sequence boundary codes.
package seq6_pkg;

  typedef enum logic [2:0] {
    OpStep  = 3'd0,
    OpRun   = 3'd1,
    OpClear = 3'd2,
    OpLoad  = 3'd3
  } seq6_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } seq6_state_e;

  // Forward order of the six legal codes; 010 and 101 are never held.
  localparam logic [5:0][2:0] SEQ_CODES = {3'b100, 3'b110, 3'b111, 3'b001, 3'b011, 3'b000};
  localparam logic [2:0] SEQ_FIRST = 3'b000;
  localparam logic [2:0] SEQ_LAST  = 3'b100;

endpackage

// File: rtl/seq6_next.sv
// Combinational successor of a sequence code in either direction, with the
// boundary-crossing flag and a legality flag for the input code.
module seq6_next
  import seq6_pkg::*;
(
  input  logic [2:0] cur,
  input  logic       dir,
  output logic [2:0] nxt,
  output logic       wrap,
  output logic       legal
);

  always_comb begin
    nxt   = SEQ_FIRST;
    legal = 1'b1;
    case (cur)
      3'b000:  nxt = dir ? 3'b100 : 3'b011;
      3'b011:  nxt = dir ? 3'b000 : 3'b001;
      3'b001:  nxt = dir ? 3'b011 : 3'b111;
      3'b111:  nxt = dir ? 3'b001 : 3'b110;
      3'b110:  nxt = dir ? 3'b111 : 3'b100;
      3'b100:  nxt = dir ? 3'b110 : 3'b000;
      // Unreachable codes recover to the start of the sequence.
      default: legal = 1'b0;
    endcase
    wrap = legal & (dir ? (cur == SEQ_FIRST) : (cur == SEQ_LAST));
  end

endmodule

// File: rtl/seq6_run_ctrl.sv
// Command-driven controller for the 6-state sequence counter: single steps,
// multi-step runs with halt, clear and load, plus done/wrap/err status.
module seq6_run_ctrl
  import seq6_pkg::*;
#(
  parameter int unsigned NSTEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [NSTEP_W-1:0] cmd_n,
  input  logic               cmd_dir,
  input  logic               halt,
  output logic [2:0]         count,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               err
);

  seq6_state_e        state;
  logic [NSTEP_W-1:0] remaining;
  logic               dir_q;

  logic       step_dir;
  logic [2:0] step_nxt;
  logic       step_wrap;
  logic       step_legal;
  logic       load_legal;
  logic [2:0] unused_load_nxt;
  logic       unused_load_wrap;

  // A run uses the direction latched at accept; a STEP uses the live input.
  assign step_dir  = (state == StRun) ? dir_q : cmd_dir;
  assign cmd_ready = (state == StIdle);
  assign busy      = (state == StRun);

  seq6_next u_step (
    .cur   (count),
    .dir   (step_dir),
    .nxt   (step_nxt),
    .wrap  (step_wrap),
    .legal (step_legal)
  );

  seq6_next u_load_chk (
    .cur   (cmd_n[2:0]),
    .dir   (1'b0),
    .nxt   (unused_load_nxt),
    .wrap  (unused_load_wrap),
    .legal (load_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      remaining <= '0;
      dir_q     <= 1'b0;
      count     <= SEQ_FIRST;
      done      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            case (cmd_op)
              OpStep: begin
                count <= step_legal ? step_nxt : SEQ_FIRST;
                wrap  <= step_wrap;
                done  <= 1'b1;
              end
              OpRun: begin
                if (cmd_n == '0) begin
                  done <= 1'b1;
                end else begin
                  state     <= StRun;
                  remaining <= cmd_n;
                  dir_q     <= cmd_dir;
                end
              end
              OpClear: begin
                count <= SEQ_FIRST;
                err   <= 1'b0;
                done  <= 1'b1;
              end
              OpLoad: begin
                if (load_legal) begin
                  count <= cmd_n[2:0];
                  done  <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        StRun: begin
          // halt wins over the step, including the final one.
          if (halt) begin
            state <= StIdle;
          end else begin
            count     <= step_legal ? step_nxt : SEQ_FIRST;
            wrap      <= step_wrap;
            remaining <= remaining - 1'b1;
            if (remaining == NSTEP_W'(1)) begin
              state <= StIdle;
              done  <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
